// File: rtl/bus_master_port.sv
// CPU-side initiator on the shared tristate bus: latches one access, drives it, and returns ack/rdata or a timeout error.
// Latency: request from the accept edge A; ack is high in the cycle after A+6 with a 4-wait slave, or after A+TIMEOUT+1 on timeout.
// Backpressure: cpu_req is sampled only in IDLE; cpu_busy is high from acceptance until the bus has been released again.

module bus_master_port #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_req,
    input  logic        cpu_r_w,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic        bus_err,
    output logic [31:0] address,
    output logic        r_w,
    output logic        request,
    inout  wire  [31:0] data,
    input  logic        ready_in
);

    if (TIMEOUT < 6 || TIMEOUT > 255 || (2 ** CNT_W) <= TIMEOUT) begin : g_bad_param
        $error("bus_master_port: TIMEOUT must be 6..255 and fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_RECOVER
    } state_t;

    typedef struct packed {
        logic        r_w;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    state_t           state;
    state_t           state_nxt;
    acc_t             acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             ack_q;
    logic             err_q;

    logic             accept;
    logic             at_limit;
    logic             hit;
    logic             expire;
    logic             drive_en;

    // Ready on the terminal-count edge still counts as a normal completion.
    always_comb begin
        accept   = (state == ST_IDLE) && cpu_req;
        at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));
        hit      = (state == ST_REQ) && ready_in;
        expire   = (state == ST_REQ) && !ready_in && at_limit;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cpu_req) state_nxt = ST_REQ;
            ST_REQ:     if (ready_in || at_limit) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_RECOVER;
            ST_RECOVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        request  = (state == ST_REQ);
        cpu_busy = (state != ST_IDLE);
        drive_en = request && acc_q.r_w;
    end

    // Only a write in REQ drives the bus; reads and every other state leave it floating.
    assign data      = drive_en ? acc_q.wdata : 32'bz;
    assign address   = acc_q.addr;
    assign r_w       = acc_q.r_w;
    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign bus_err   = err_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= '{r_w: cpu_r_w, addr: cpu_addr, wdata: cpu_wdata};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else if (state == ST_REQ) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Write completions leave the last read data in place.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rdata_q <= '0;
        end else if (hit && !acc_q.r_w) begin
            rdata_q <= data;
        end else if (expire) begin
            rdata_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= (state == ST_DONE);
            if (expire) begin
                err_q <= 1'b1;
            end else if (state == ST_RECOVER) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a 4-wait-state slave at 0x00-0xFF, a reference memory/latency model and directed plus random accesses.

module tb_bus_master_port;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_r_w = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        bus_err;
    logic [31:0] address;
    logic        r_w;
    logic        request;
    wire  [31:0] data_bus;
    wire         ready_w;

    logic        slave_rdy = 1'b0;
    logic        slave_oe = 1'b0;
    logic [31:0] slave_dq = '0;
    logic        force_rdy = 1'b0;
    logic        force_oe = 1'b0;
    logic [31:0] force_dq = '0;
    wire         tb_oe = slave_oe | force_oe;

    assign ready_w  = slave_rdy | force_rdy;
    assign data_bus = slave_oe ? slave_dq : (force_oe ? force_dq : 32'bz);

    int compares = 0;
    int errors = 0;
    int latch_cnt = 0;
    int ack_cnt = 0;
    bit mon_en = 1'b0;

    logic [31:0] slv_mem [0:255];
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rdata = '0;

    bus_master_port #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .clrn(clrn),
        .cpu_req(cpu_req), .cpu_r_w(cpu_r_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy), .bus_err(bus_err),
        .address(address), .r_w(r_w), .request(request), .data(data_bus), .ready_in(ready_w)
    );

    always #5 clk = ~clk;

    // 4-wait slave: latches the cycle after request rises, ready for one cycle four cycles later, commits writes on ready.
    initial begin
        int st;
        int k;
        logic [31:0] la;
        logic [31:0] ld;
        logic lrw;
        st = 0; k = 0; la = '0; ld = '0; lrw = 1'b0;
        for (int i = 0; i < 256; i++) slv_mem[i] = '0;
        forever begin
            @(negedge clk);
            case (st)
                0: if (request && address < 32'h100) begin
                    la = address; lrw = r_w; ld = data_bus; k = 0; st = 1; latch_cnt++;
                end
                1: if (!request) st = 0;
                   else begin
                       k++;
                       if (k == 4) begin
                           slave_rdy = 1'b1;
                           if (lrw) slv_mem[la[7:0]] = ld;
                           else begin slave_dq = slv_mem[la[7:0]]; slave_oe = 1'b1; end
                           st = 2;
                       end
                   end
                2: begin slave_rdy = 1'b0; slave_oe = 1'b0; st = 3; end
                default: if (!request) st = 0;
            endcase
        end
    end

    // Bus-contention watch: with no bench driver and no write in REQ the bus must be floating.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cpu_ack) ack_cnt++;
            if (mon_en && !tb_oe && !(request && r_w)) begin
                compares++;
                if (data_bus !== 32'h0 && data_bus !== 32'hz) begin
                    errors++;
                    $display("FAIL bus_float: data got %h required Z (request=%0d r_w=%0d)", data_bus, request, r_w);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required completion before time limit");
        $fatal(1);
    end

    task automatic model_access(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                                output int e_lat, output int e_req, output logic e_err, output logic [31:0] e_rd);
        if (addr < 32'h100) begin
            e_lat = 7; e_req = 5; e_err = 1'b0;
            if (rw) ref_mem[int'(addr)] = wd;
            else ref_rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 32'h0;
        end else begin
            e_lat = TIMEOUT + 2; e_req = TIMEOUT; e_err = 1'b1; ref_rdata = 32'h0;
        end
        e_rd = ref_rdata;
    endtask

    // lat = edges from acceptance to the edge where the CPU samples cpu_ack high.
    task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                             output int lat, output int req_cyc, output logic [31:0] rd, output logic err, output bit ok);
        int n;
        ok = 1'b1; lat = 0; req_cyc = 0; rd = '0; err = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_r_w = rw; cpu_addr = addr; cpu_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_busy && n < 20);
        cpu_req = 1'b0;
        if (!cpu_busy) begin ok = 1'b0; return; end
        req_cyc = request ? 1 : 0;
        n = 0;
        while (!cpu_ack && n < 100) begin
            @(negedge clk); n++;
            if (request) req_cyc++;
        end
        if (!cpu_ack) begin ok = 1'b0; return; end
        lat = n + 1; rd = cpu_rdata; err = bus_err;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        #2 clrn = 1'b0;
        repeat (3) @(negedge clk);
        compares++; if (request !== 1'b0) begin errors++; $display("FAIL rst_request: got %0d required 0", request); end
        compares++; if (r_w !== 1'b0) begin errors++; $display("FAIL rst_r_w: got %0d required 0", r_w); end
        compares++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %0d required 0", cpu_ack); end
        compares++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %0d required 0", bus_err); end
        compares++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d required 0", cpu_busy); end
        compares++; if (address !== 32'h0) begin errors++; $display("FAIL rst_address: got %h required 0", address); end
        compares++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", cpu_rdata); end
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        compares++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %0d required 0", cpu_busy); end
    endtask

    task automatic test_write_read();
        int lat, rq, el, erq, l0;
        logic [31:0] rd, erd;
        logic err, eerr;
        bit ok;
        l0 = latch_cnt;
        model_access(1'b1, 32'h10, 32'hDEADBEEF, el, erq, eerr, erd);
        do_access(1'b1, 32'h10, 32'hDEADBEEF, lat, rq, rd, err, ok);
        compares++; if (!ok || lat != el) begin errors++; $display("FAIL wr_latency: got %0d required %0d (done=%0d)", lat, el, ok); end
        compares++; if (rq != erq) begin errors++; $display("FAIL wr_request_cycles: got %0d required %0d", rq, erq); end
        compares++; if (err !== eerr) begin errors++; $display("FAIL wr_bus_err: got %0d required %0d", err, eerr); end
        model_access(1'b0, 32'h10, 32'h0BADF00D, el, erq, eerr, erd);
        do_access(1'b0, 32'h10, 32'h0BADF00D, lat, rq, rd, err, ok);
        compares++; if (!ok || lat != el) begin errors++; $display("FAIL rd_latency: got %0d required %0d (done=%0d)", lat, el, ok); end
        compares++; if (rq != erq) begin errors++; $display("FAIL rd_request_cycles: got %0d required %0d", rq, erq); end
        compares++; if (err !== eerr) begin errors++; $display("FAIL rd_bus_err: got %0d required %0d", err, eerr); end
        compares++; if (rd !== erd) begin errors++; $display("FAIL rd_data: got %h required %h", rd, erd); end
        compares++; if (latch_cnt - l0 != 2) begin errors++; $display("FAIL wr_rd_slave_latches: got %0d required 2", latch_cnt - l0); end
    endtask

    task automatic test_timeout();
        int lat, rq, el, erq;
        logic [31:0] rd, erd;
        logic err, eerr;
        bit ok;
        model_access(1'b0, 32'h1000, 32'hA5A5A5A5, el, erq, eerr, erd);
        do_access(1'b0, 32'h1000, 32'hA5A5A5A5, lat, rq, rd, err, ok);
        compares++; if (!ok || lat != el) begin errors++; $display("FAIL to_latency: got %0d required %0d (done=%0d)", lat, el, ok); end
        compares++; if (rq != erq) begin errors++; $display("FAIL to_request_cycles: got %0d required %0d", rq, erq); end
        compares++; if (err !== eerr) begin errors++; $display("FAIL to_bus_err: got %0d required %0d", err, eerr); end
        compares++; if (rd !== erd) begin errors++; $display("FAIL to_rdata: got %h required %h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        int lat, rq, el, erq, l0, acks, gap, min_gap, n;
        logic [31:0] rd, erd, e0, e1;
        logic [31:0] rds [2];
        logic err, eerr;
        bit ok;
        model_access(1'b1, 32'h20, $urandom, el, erq, eerr, erd);
        do_access(1'b1, 32'h20, ref_mem[32'h20], lat, rq, rd, err, ok);
        model_access(1'b1, 32'h21, $urandom, el, erq, eerr, erd);
        do_access(1'b1, 32'h21, ref_mem[32'h21], lat, rq, rd, err, ok);
        model_access(1'b0, 32'h20, 32'h0, el, erq, eerr, e0);
        model_access(1'b0, 32'h21, 32'h0, el, erq, eerr, e1);
        l0 = latch_cnt;
        @(negedge clk);
        cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 32'h20; cpu_wdata = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_busy && n < 20);
        acks = 0; gap = 0; min_gap = 1000;
        rds[0] = '0; rds[1] = '0;
        for (int i = 0; i < 60 && acks < 2; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                rds[acks] = cpu_rdata; acks++;
                if (acks == 1) cpu_addr = 32'h21;
            end
            if (!request) gap++;
            else if (gap > 0) begin
                if (gap < min_gap) min_gap = gap;
                gap = 0;
            end
        end
        cpu_req = 1'b0;
        compares++; if (acks != 2) begin errors++; $display("FAIL b2b_acks: got %0d required 2", acks); end
        compares++; if (rds[0] !== e0) begin errors++; $display("FAIL b2b_data0: got %h required %h", rds[0], e0); end
        compares++; if (rds[1] !== e1) begin errors++; $display("FAIL b2b_data1: got %h required %h", rds[1], e1); end
        compares++; if (min_gap < 2 || min_gap == 1000) begin errors++; $display("FAIL b2b_idle_gap: got %0d required >=2", min_gap); end
        compares++; if (latch_cnt - l0 != 2) begin errors++; $display("FAIL b2b_slave_latches: got %0d required 2", latch_cnt - l0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int lat, rq, el, erq, n, a0;
        logic [31:0] rd, erd;
        logic err, eerr;
        bit ok;
        model_access(1'b1, 32'h05, 32'hCAFE0005, el, erq, eerr, erd);
        do_access(1'b1, 32'h05, 32'hCAFE0005, lat, rq, rd, err, ok);
        @(negedge clk);
        cpu_req = 1'b1; cpu_r_w = 1'b1; cpu_addr = 32'h05; cpu_wdata = 32'h55AA55AA;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_busy && n < 20);
        cpu_req = 1'b0;
        a0 = ack_cnt;
        repeat (3) @(posedge clk);
        #1 clrn = 1'b0;
        #1;
        compares++; if (request !== 1'b0) begin errors++; $display("FAIL mid_rst_request: got %0d required 0", request); end
        compares++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0d required 0", cpu_busy); end
        compares++; if (data_bus !== 32'h0 && data_bus !== 32'hz) begin errors++; $display("FAIL mid_rst_data: got %h required Z", data_bus); end
        compares++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h required 0", cpu_rdata); end
        ref_rdata = 32'h0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (8) @(negedge clk);
        compares++; if (ack_cnt != a0) begin errors++; $display("FAIL mid_rst_no_ack: got %0d acks required 0", ack_cnt - a0); end
        model_access(1'b0, 32'h05, 32'h0, el, erq, eerr, erd);
        do_access(1'b0, 32'h05, 32'h0, lat, rq, rd, err, ok);
        compares++; if (!ok || rd !== erd) begin errors++; $display("FAIL mid_rst_readback: got %h required %h (done=%0d)", rd, erd, ok); end
    endtask

    task automatic test_input_change();
        int lat, rq, el, erq, n;
        logic [31:0] rd, erd;
        logic err, eerr;
        bit ok;
        @(negedge clk);
        cpu_req = 1'b1; cpu_r_w = 1'b1; cpu_addr = 32'h08; cpu_wdata = 32'h12345678;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_busy && n < 20);
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_addr = $urandom | 32'h100; cpu_wdata = $urandom;
        @(negedge clk);
        compares++; if (address !== 32'h08) begin errors++; $display("FAIL chg_address: got %h required 00000008", address); end
        n = 0;
        while (!cpu_ack && n < 40) begin @(negedge clk); n++; end
        compares++; if (!cpu_ack) begin errors++; $display("FAIL chg_write_ack: got 0 required 1"); end
        model_access(1'b1, 32'h08, 32'h12345678, el, erq, eerr, erd);
        model_access(1'b0, 32'h08, 32'h0, el, erq, eerr, erd);
        do_access(1'b0, 32'h08, 32'hFFFFFFFF, lat, rq, rd, err, ok);
        compares++; if (!ok || rd !== erd) begin errors++; $display("FAIL chg_readback: got %h required %h (done=%0d)", rd, erd, ok); end
    endtask

    task automatic test_ready_at_terminal();
        int n, e, a0, lat;
        logic [31:0] v, rd;
        logic err;
        v = $urandom;
        @(negedge clk);
        cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 32'h1000; cpu_wdata = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_busy && n < 20);
        cpu_req = 1'b0;
        a0 = ack_cnt - (cpu_ack ? 1 : 0);
        e = 0; lat = 0; rd = '0; err = 1'b1;
        // Ready is raised so the master first samples it with the counter at TIMEOUT-1, then held through DONE/RECOVER/IDLE.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); e++;
            if (e == TIMEOUT - 1) begin force_rdy = 1'b1; force_oe = 1'b1; force_dq = v; end
            if (cpu_ack && lat == 0) begin lat = e + 1; rd = cpu_rdata; err = bus_err; end
            if (e == TIMEOUT + 4) begin force_rdy = 1'b0; force_oe = 1'b0; end
        end
        ref_rdata = v;
        compares++; if (lat != TIMEOUT + 2) begin errors++; $display("FAIL term_latency: got %0d required %0d", lat, TIMEOUT + 2); end
        compares++; if (err !== 1'b0) begin errors++; $display("FAIL term_bus_err: got %0d required 0", err); end
        compares++; if (rd !== v) begin errors++; $display("FAIL term_rdata: got %h required %h", rd, v); end
        compares++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL term_ack_count: got %0d required 1", ack_cnt - a0); end
        compares++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL term_idle_busy: got %0d required 0", cpu_busy); end
    endtask

    task automatic test_random();
        int lat, rq, el, erq;
        logic [31:0] rd, erd, a, wd;
        logic err, eerr, rw;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? (32'h1000 + $urandom_range(0, 255)) : $urandom_range(0, 255);
            rw = $urandom_range(0, 1);
            wd = $urandom;
            model_access(rw, a, wd, el, erq, eerr, erd);
            do_access(rw, a, wd, lat, rq, rd, err, ok);
            compares++; if (!ok || lat != el) begin errors++; $display("FAIL rnd%0d_latency: got %0d required %0d (done=%0d)", i, lat, el, ok); end
            compares++; if (rq != erq) begin errors++; $display("FAIL rnd%0d_request_cycles: got %0d required %0d", i, rq, erq); end
            compares++; if (err !== eerr) begin errors++; $display("FAIL rnd%0d_bus_err: got %0d required %0d", i, err, eerr); end
            compares++; if (rd !== erd) begin errors++; $display("FAIL rnd%0d_rdata: got %h required %h", i, rd, erd); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        test_input_change();
        test_ready_at_terminal();
        test_random();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
